instr_fetch: RTL and testbench



---
 rtl/instr_fetch_if.sv | 43 ++++
 rtl/instr_fetch.sv | 117 +++++++++++
 tb/tb_instr_fetch.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: PC handshake, instruction-memory read port and IR handshake to decode.
// INSTR_FETCH_FIELDS_EN adds pre-sliced instruction fields toward decode.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              ir_valid;
  logic              ir_ready;
  logic [15:0]       ir_instr;
  logic [ADDR_W-1:0] ir_pc;
`ifdef INSTR_FETCH_FIELDS_EN
  logic [2:0]        ir_opcode;
  logic [2:0]        ir_ra;
  logic [2:0]        ir_rb;
  logic [2:0]        ir_rc;
  logic [15:0]       ir_simm;
  logic [9:0]        ir_imm10;
`endif

  // master: the fetch stage itself; slave: PC stage, memory and decode around it
  modport master (
    input  pc_in, pc_valid, flush, imem_ack, imem_rdata, ir_ready,
    output pc_ready, imem_req, imem_addr, ir_valid, ir_instr, ir_pc
`ifdef INSTR_FETCH_FIELDS_EN
    , output ir_opcode, ir_ra, ir_rb, ir_rc, ir_simm, ir_imm10
`endif
  );

  modport slave (
    output pc_in, pc_valid, flush, imem_ack, imem_rdata, ir_ready,
    input  pc_ready, imem_req, imem_addr, ir_valid, ir_instr, ir_pc
`ifdef INSTR_FETCH_FIELDS_EN
    , input ir_opcode, ir_ra, ir_rb, ir_rc, ir_simm, ir_imm10
`endif
  );
endinterface

// File: rtl/instr_fetch.sv
// RiSC-16 instruction fetch: one outstanding variable-latency read, single IR toward decode, flush with drain.
// Optional INSTR_FETCH_FIELDS_EN exposes decoded instruction fields combinationally from the IR.
module instr_fetch #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  instr_fetch_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FULL,
    S_DRAIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pend_pc;
  logic              accept;

  always_comb begin
    bus.pc_ready = !rst && !bus.flush &&
                   ((state == S_IDLE) || ((state == S_FULL) && bus.ir_ready));
    accept       = bus.pc_valid && bus.pc_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pend_pc       <= '0;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= '0;
      bus.ir_valid  <= 1'b0;
      bus.ir_instr  <= '0;
      bus.ir_pc     <= '0;
    end else if (bus.flush) begin
      // IR contents are kept, only the valid flag drops; an unanswered request must still drain
      bus.ir_valid <= 1'b0;
      unique case (state)
        S_IDLE, S_FULL: begin
          state        <= S_IDLE;
          bus.imem_req <= 1'b0;
        end
        S_WAIT, S_DRAIN: begin
          if (bus.imem_ack) begin
            state        <= S_IDLE;
            bus.imem_req <= 1'b0;
          end else begin
            state        <= S_DRAIN;
            bus.imem_req <= 1'b1;
          end
        end
        default: begin
          state        <= S_IDLE;
          bus.imem_req <= 1'b0;
        end
      endcase
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state         <= S_WAIT;
            pend_pc       <= bus.pc_in;
            bus.imem_addr <= bus.pc_in;
            bus.imem_req  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.imem_ack) begin
            state        <= S_FULL;
            bus.ir_instr <= bus.imem_rdata;
            bus.ir_pc    <= pend_pc;
            bus.ir_valid <= 1'b1;
            bus.imem_req <= 1'b0;
          end
        end
        S_FULL: begin
          if (bus.ir_ready) begin
            bus.ir_valid <= 1'b0;
            if (accept) begin
              state         <= S_WAIT;
              pend_pc       <= bus.pc_in;
              bus.imem_addr <= bus.pc_in;
              bus.imem_req  <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (bus.imem_ack) begin
            state        <= S_IDLE;
            bus.imem_req <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          bus.imem_req <= 1'b0;
          bus.ir_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef INSTR_FETCH_FIELDS_EN
  always_comb begin
    bus.ir_opcode = bus.ir_instr[15:13];
    bus.ir_ra     = bus.ir_instr[12:10];
    bus.ir_rb     = bus.ir_instr[9:7];
    bus.ir_rc     = bus.ir_instr[2:0];
    bus.ir_simm   = {{9{bus.ir_instr[6]}}, bus.ir_instr[6:0]};
    bus.ir_imm10  = bus.ir_instr[9:0];
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed table-driven bench for instr_fetch plus hand-written multi-cycle sequences.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_if #(.ADDR_W(16)) bus ();

  instr_fetch #(.ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pv;
    logic [15:0] pc;
    logic        fl;
    logic        ack;
    logic [15:0] rd;
    logic        rdy;
    logic        e_prdy;   // pc_ready before the edge
    logic        e_req;    // registered values after the edge
    logic [15:0] e_addr;
    logic        e_irv;
    logic [15:0] e_instr;
    logic [15:0] e_irpc;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic r, logic pv, logic [15:0] pc, logic fl, logic ack,
                              logic [15:0] rd, logic rdy, logic prdy, logic req,
                              logic [15:0] addr, logic irv, logic [15:0] instr,
                              logic [15:0] irpc);
    vec_t v;
    v.rst = r; v.pv = pv; v.pc = pc; v.fl = fl; v.ack = ack; v.rd = rd; v.rdy = rdy;
    v.e_prdy = prdy; v.e_req = req; v.e_addr = addr; v.e_irv = irv;
    v.e_instr = instr; v.e_irpc = irpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic pv, input logic [15:0] pc, input logic fl,
                       input logic ack, input logic [15:0] rd, input logic rdy);
    rst = r; bus.pc_valid = pv; bus.pc_in = pc; bus.flush = fl;
    bus.imem_ack = ack; bus.imem_rdata = rd; bus.ir_ready = rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    waited;
    logic  seen;

    //             rst pv pc       fl ack rd       rdy | prdy req addr     irv instr    irpc
    // reset with pc_valid high
    vecs.push_back(mk(1, 1, 16'h1234, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 1, 16'h1234, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000));
    // single fetch, held under backpressure for 3 cycles
    vecs.push_back(mk(0, 1, 16'h0004, 0, 0, 16'h0000, 0, 1, 1, 16'h0004, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hA48E, 0, 0, 0, 16'h0004, 1, 16'hA48E, 16'h0004));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0004, 1, 16'hA48E, 16'h0004));
    vecs.push_back(mk(0, 1, 16'h0009, 0, 0, 16'h0000, 0, 0, 0, 16'h0004, 1, 16'hA48E, 16'h0004));
    vecs.push_back(mk(0, 1, 16'h0009, 0, 0, 16'h0000, 0, 0, 0, 16'h0004, 1, 16'hA48E, 16'h0004));
    // consume + accept next in same cycle
    vecs.push_back(mk(0, 1, 16'h0005, 0, 0, 16'h0000, 1, 1, 1, 16'h0005, 0, 16'hA48E, 16'h0004));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h2C03, 0, 0, 0, 16'h0005, 1, 16'h2C03, 16'h0005));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 16'h0005, 0, 16'h2C03, 16'h0005));
    // flush in WAIT, flush held in DRAIN, ack 3 cycles after flush
    vecs.push_back(mk(0, 1, 16'h0010, 0, 0, 16'h0000, 0, 1, 1, 16'h0010, 0, 16'h2C03, 16'h0005));
    vecs.push_back(mk(0, 1, 16'h0011, 1, 0, 16'h0000, 0, 0, 1, 16'h0010, 0, 16'h2C03, 16'h0005));
    vecs.push_back(mk(0, 1, 16'h0011, 1, 0, 16'h0000, 0, 0, 1, 16'h0010, 0, 16'h2C03, 16'h0005));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 16'h0010, 0, 16'h2C03, 16'h0005));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hFFFF, 0, 0, 0, 16'h0010, 0, 16'h2C03, 16'h0005));
    // stray ack in IDLE ignored
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h1111, 0, 1, 0, 16'h0010, 0, 16'h2C03, 16'h0005));
    vecs.push_back(mk(0, 1, 16'hBEEF, 0, 0, 16'h0000, 0, 1, 1, 16'hBEEF, 0, 16'h2C03, 16'h0005));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h1357, 0, 0, 0, 16'hBEEF, 1, 16'h1357, 16'hBEEF));
    // flush in FULL with pc_valid: IR kept, valid dropped
    vecs.push_back(mk(0, 1, 16'h0020, 1, 0, 16'h0000, 0, 0, 0, 16'hBEEF, 0, 16'h1357, 16'hBEEF));
    // flush coincident with ack and pc_valid
    vecs.push_back(mk(0, 1, 16'h0030, 0, 0, 16'h0000, 0, 1, 1, 16'h0030, 0, 16'h1357, 16'hBEEF));
    vecs.push_back(mk(0, 1, 16'h0040, 1, 1, 16'hDEAD, 0, 0, 0, 16'h0030, 0, 16'h1357, 16'hBEEF));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 16'h0030, 0, 16'h1357, 16'hBEEF));
    // back-to-back with zero-wait memory: one instruction per 2 cycles
    vecs.push_back(mk(0, 1, 16'h0100, 0, 0, 16'h0000, 1, 1, 1, 16'h0100, 0, 16'h1357, 16'hBEEF));
    vecs.push_back(mk(0, 1, 16'h0101, 0, 1, 16'h0101, 1, 0, 0, 16'h0100, 1, 16'h0101, 16'h0100));
    vecs.push_back(mk(0, 1, 16'h0101, 0, 0, 16'h0000, 1, 1, 1, 16'h0101, 0, 16'h0101, 16'h0100));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0202, 0, 0, 0, 16'h0101, 1, 16'h0202, 16'h0101));
    // reset mid-fetch, then late ack ignored
    vecs.push_back(mk(0, 1, 16'h0200, 0, 0, 16'h0000, 1, 1, 1, 16'h0200, 0, 16'h0202, 16'h0101));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hBBBB, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pv, vecs[i].pc, vecs[i].fl, vecs[i].ack, vecs[i].rd, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d.pc_ready", i), 32'(bus.pc_ready), 32'(vecs[i].e_prdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.imem_req", i),  32'(bus.imem_req),  32'(vecs[i].e_req));
      chk($sformatf("v%0d.imem_addr", i), 32'(bus.imem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d.ir_valid", i),  32'(bus.ir_valid),  32'(vecs[i].e_irv));
      chk($sformatf("v%0d.ir_instr", i),  32'(bus.ir_instr),  32'(vecs[i].e_instr));
      chk($sformatf("v%0d.ir_pc", i),     32'(bus.ir_pc),     32'(vecs[i].e_irpc));
    end

    // long memory latency: request and address stay stable until ack
    drive(0, 1, 16'h0777, 0, 0, 16'h0000, 0);
    @(posedge clk); #1;
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("lat%0d.imem_req", c),  32'(bus.imem_req),  32'd1);
      chk($sformatf("lat%0d.imem_addr", c), 32'(bus.imem_addr), 32'h0777);
      chk($sformatf("lat%0d.ir_valid", c),  32'(bus.ir_valid),  32'd0);
      @(posedge clk); #1;
    end
`ifdef INSTR_FETCH_FIELDS_EN
    drive(0, 0, 16'h0000, 0, 1, 16'hA4FE, 0);
`else
    drive(0, 0, 16'h0000, 0, 1, 16'h5A5A, 0);
`endif
    @(posedge clk); #1;
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    waited = 0;
    seen = bus.ir_valid;
    while (!seen && waited < 4) begin
      @(posedge clk); #1;
      waited++;
      seen = bus.ir_valid;
    end
    chk("lat.ir_valid_within_bound", 32'(seen), 32'd1);
    chk("lat.ir_valid_latency", 32'(waited), 32'd0);
    chk("lat.ir_pc", 32'(bus.ir_pc), 32'h0777);
`ifdef INSTR_FETCH_FIELDS_EN
    chk("fld.ir_instr",  32'(bus.ir_instr),  32'hA4FE);
    chk("fld.ir_opcode", 32'(bus.ir_opcode), 32'd5);
    chk("fld.ir_ra",     32'(bus.ir_ra),     32'd1);
    chk("fld.ir_rb",     32'(bus.ir_rb),     32'd1);
    chk("fld.ir_rc",     32'(bus.ir_rc),     32'd6);
    chk("fld.ir_simm",   32'(bus.ir_simm),   32'hFFFE);
    chk("fld.ir_imm10",  32'(bus.ir_imm10),  32'h00FE);
`else
    chk("lat.ir_instr", 32'(bus.ir_instr), 32'h5A5A);
`endif
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 1);
    @(posedge clk); #1;
    chk("end.ir_valid", 32'(bus.ir_valid), 32'd0);
    chk("end.imem_req", 32'(bus.imem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
